// File: rtl/decode_ctrl_if.sv
// ============================================================================
// decode_ctrl_if : fetch / extender / execute bundle for the decode stage
// Revision 1.0
// ============================================================================
`default_nettype none

interface decode_ctrl_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] ext_in;
  logic [2:0]      ext_sel;
  logic [XLEN-1:0] ext_out;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_imm_sel;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, ext_out, out_ready,
    output in_ready, ext_in, ext_sel,
    output out_valid, out_instr, out_pc, out_imm, out_imm_sel, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, ext_out, out_ready,
    input  in_ready, ext_in, ext_sel,
    input  out_valid, out_instr, out_pc, out_imm, out_imm_sel, out_illegal
  );
endinterface

`default_nettype wire

// File: rtl/decode_ctrl.sv
// ============================================================================
// decode_ctrl : RV32I immediate-select decode with skid-buffered output stage
// Revision 1.0
// ============================================================================
`default_nettype none

module decode_ctrl #(
  parameter int XLEN        = 32,
  parameter int STALL_CNT_W = 16
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   flush,
  decode_ctrl_if.slave                bus,
  output logic [STALL_CNT_W-1:0]      stall_cnt
);

  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_fence  = 7'b0001111;
  localparam logic [6:0] c_op_system = 7'b1110011;
  localparam logic [6:0] c_op_op     = 7'b0110011;

  localparam logic [2:0] c_sel_i    = 3'b000;
  localparam logic [2:0] c_sel_u    = 3'b001;
  localparam logic [2:0] c_sel_j    = 3'b010;
  localparam logic [2:0] c_sel_b    = 3'b011;
  localparam logic [2:0] c_sel_s    = 3'b100;
  localparam logic [2:0] c_sel_none = 3'b111;

  localparam logic [STALL_CNT_W-1:0] c_cnt_one = 1;
  localparam logic [STALL_CNT_W-1:0] c_cnt_max = '1;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      sel;
    logic            illegal;
  } entry_t;

  localparam entry_t c_entry_rst = '{instr: '0, pc: '0, imm: '0, sel: 3'b111, illegal: 1'b0};

  logic [2:0]            w_sel;
  logic                  w_illegal;
  logic                  w_accept;
  logic                  w_out_free;
  entry_t                w_in_entry;
  entry_t                r_out;
  entry_t                r_skid;
  logic                  r_out_valid;
  logic                  r_skid_valid;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  // Opcodes with instr[1:0] != 2'b11 never match a listed case, so they fall to illegal.
  always_comb begin
    w_sel     = c_sel_none;
    w_illegal = 1'b0;
    case (bus.in_instr[6:0])
      c_op_lui, c_op_auipc: w_sel = c_sel_u;
      c_op_jal:             w_sel = c_sel_j;
      c_op_branch:          w_sel = c_sel_b;
      c_op_store:           w_sel = c_sel_s;
      c_op_jalr, c_op_load, c_op_imm, c_op_fence, c_op_system: w_sel = c_sel_i;
      c_op_op:              w_sel = c_sel_none;
      default:              w_illegal = 1'b1;
    endcase
  end

  assign bus.ext_in  = bus.in_instr;
  assign bus.ext_sel = w_sel;

  assign w_accept   = bus.in_valid && !r_skid_valid;
  assign w_out_free = !r_out_valid || bus.out_ready;
  assign w_in_entry = '{instr: bus.in_instr, pc: bus.in_pc, imm: bus.ext_out,
                        sel: w_sel, illegal: w_illegal};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out        <= c_entry_rst;
      r_skid       <= c_entry_rst;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      // A full skid implies in_ready was low, so no new entry competes with it.
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out       <= w_in_entry;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid       <= w_in_entry;
      r_skid_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !bus.out_ready && r_stall_cnt != c_cnt_max) begin
      r_stall_cnt <= r_stall_cnt + c_cnt_one;
    end
  end

  assign bus.in_ready    = !r_skid_valid;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_instr   = r_out.instr;
  assign bus.out_pc      = r_out.pc;
  assign bus.out_imm     = r_out.imm;
  assign bus.out_imm_sel = r_out.sel;
  assign bus.out_illegal = r_out.illegal;
  assign stall_cnt       = r_stall_cnt;

endmodule

`default_nettype wire
